// File: rtl/pipe_pkg.sv
// Shared encodings and constants for the pipeline sequencing controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FLUSH    = 2'b10
  } state_e;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam int         WAIT_CNT_W = 8;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// feeds either source of the instruction in ID.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  output logic             hazard
);

  // $zero is never a real dependency, so a load into it cannot stall.
  assign hazard = id_ex_memread
                & (id_ex_rt != REG_W'(REG_ZERO))
                & ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));

endmodule

// File: rtl/pipe_ctl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: load-use stalls,
// taken-branch flushes, data-memory waits with timeout. Optional performance
// counters are enabled with the PIPE_CTL_PERF_EN macro.
module pipe_ctl
  import pipe_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int REG_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             ex_mem_branch,
  input  logic             ex_mem_zero,
  input  logic             ex_mem_memreq,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             pc_src,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [1:0]       state
`ifdef PIPE_CTL_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events
`endif
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(MEM_WAIT_MAX);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  mem_err_q, mem_err_d;

  logic hazard;
  logic branch_taken;
  logic mem_wait;
  logic timeout;

  load_use_detect #(.REG_W(REG_W)) u_lud (
    .id_ex_memread (id_ex_memread),
    .id_ex_rt      (id_ex_rt),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .hazard        (hazard)
  );

  assign branch_taken = ex_mem_branch & ex_mem_zero;
  assign mem_wait     = ex_mem_memreq & ~dmem_ready;
  assign timeout      = ~dmem_ready & (wait_cnt_q >= WAIT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          state_d = ST_FLUSH;
        end else if (mem_wait) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        if (mem_wait) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_CNT_W'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (timeout) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    pc_src       = 1'b0;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          pc_src       = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (mem_wait) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          mem_wb_flush = 1'b1;
        end else if (hazard) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (mem_wait) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          mem_wb_flush = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // On timeout the access is abandoned and the pipeline released.
        if (!dmem_ready && !timeout) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          mem_wb_flush = 1'b1;
        end
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_en        = 1'b0;
      pc_src       = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
    end
  end

  assign mem_err = mem_err_q;
  assign state   = state_q;

`ifdef PIPE_CTL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, ~pc_en};
    flush_events_d = flush_events_q + {31'd0, (state_q == ST_RUN) & branch_taken};
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed self-checking bench for pipe_ctl (MEM_WAIT_MAX=4); also checks the
// counters when PIPE_CTL_PERF_EN is defined.
module tb_pipe_ctl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_ex_memread;
  logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
  logic       ex_mem_branch, ex_mem_zero, ex_mem_memreq, dmem_ready;
  logic       pc_en, pc_src, if_id_en, id_ex_en, ex_mem_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic       mem_err;
  logic [1:0] state;
`ifdef PIPE_CTL_PERF_EN
  logic [31:0] stall_cycles, flush_events;
  logic [31:0] stall_base, flush_base;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctl #(.MEM_WAIT_MAX(4), .REG_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_ex_memread (id_ex_memread),
    .id_ex_rt      (id_ex_rt),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .ex_mem_branch (ex_mem_branch),
    .ex_mem_zero   (ex_mem_zero),
    .ex_mem_memreq (ex_mem_memreq),
    .dmem_ready    (dmem_ready),
    .pc_en         (pc_en),
    .pc_src        (pc_src),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_flush  (ex_mem_flush),
    .mem_wb_flush  (mem_wb_flush),
    .mem_err       (mem_err),
    .state         (state)
`ifdef PIPE_CTL_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_events  (flush_events)
`endif
  );

  // Outputs packed as {pc_en, pc_src, if_id_en, id_ex_en, ex_mem_en,
  //                    if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}.
  wire [8:0] ctl = {pc_en, pc_src, if_id_en, id_ex_en, ex_mem_en,
                    if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  localparam logic [8:0] CTL_DEF   = 9'b1_0_111_0000;
  localparam logic [8:0] CTL_ZERO  = 9'b0_0_000_0000;
  localparam logic [8:0] CTL_MEMW  = 9'b0_0_000_0001;
  localparam logic [8:0] CTL_LDUSE = 9'b0_0_011_0100;
  localparam logic [8:0] CTL_BR    = 9'b1_1_111_1110;

  task automatic set_idle();
    id_ex_memread = 1'b0;
    id_ex_rt      = 5'd0;
    if_id_rs      = 5'd0;
    if_id_rt      = 5'd0;
    ex_mem_branch = 1'b0;
    ex_mem_zero   = 1'b0;
    ex_mem_memreq = 1'b0;
    dmem_ready    = 1'b1;
  endtask

  // Drive inputs on the falling edge; Mealy outputs settle 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    ex_mem_memreq = 1'b1;
    dmem_ready    = 1'b0;
    next_cycle(); next_cycle(); #1;
    total++; if (ctl !== CTL_ZERO) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_ZERO); end
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", state); end
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL reset_mem_err got=%b exp=0", mem_err); end
    @(negedge clk); rst_n = 1'b1; #1;
    total++; if (ctl !== CTL_MEMW) begin bad++; $display("FAIL reset_release_ctl got=%b exp=%b", ctl, CTL_MEMW); end
    next_cycle(); #1;
    total++; if (state !== 2'b01) begin bad++; $display("FAIL reset_memwait_state got=%b exp=01", state); end
    dmem_ready = 1'b1; #1;
    total++; if (ctl !== CTL_DEF) begin bad++; $display("FAIL reset_ready_ctl got=%b exp=%b", ctl, CTL_DEF); end
    next_cycle(); set_idle(); #1;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_back_run got=%b exp=00", state); end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    next_cycle();
    id_ex_memread = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8; if_id_rt = 5'd3; #1;
    total++; if (ctl !== CTL_LDUSE) begin bad++; $display("FAIL lduse_stall got=%b exp=%b", ctl, CTL_LDUSE); end
    next_cycle(); set_idle(); #1;
    total++; if (ctl !== CTL_DEF) begin bad++; $display("FAIL lduse_after got=%b exp=%b", ctl, CTL_DEF); end
    total++; if (state !== 2'b00) begin bad++; $display("FAIL lduse_state got=%b exp=00", state); end
    id_ex_memread = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0; #1;
    total++; if (ctl !== CTL_DEF) begin bad++; $display("FAIL lduse_zero_reg got=%b exp=%b", ctl, CTL_DEF); end
    next_cycle(); set_idle();
    $display("test_load_use done");
  endtask

  task automatic test_branch();
    next_cycle();
    ex_mem_branch = 1'b1; ex_mem_zero = 1'b1;
    id_ex_memread = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8; #1;
    total++; if (ctl !== CTL_BR) begin bad++; $display("FAIL branch_taken got=%b exp=%b", ctl, CTL_BR); end
    next_cycle(); ex_mem_branch = 1'b0; ex_mem_zero = 1'b0; #1;
    total++; if (state !== 2'b10) begin bad++; $display("FAIL branch_flush_state got=%b exp=10", state); end
    total++; if (ctl !== CTL_DEF) begin bad++; $display("FAIL branch_hazard_masked got=%b exp=%b", ctl, CTL_DEF); end
    next_cycle(); set_idle(); #1;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL branch_back_run got=%b exp=00", state); end
    ex_mem_branch = 1'b1; ex_mem_zero = 1'b0; #1;
    total++; if (ctl !== CTL_DEF) begin bad++; $display("FAIL branch_not_taken got=%b exp=%b", ctl, CTL_DEF); end
    next_cycle(); set_idle(); #1;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL branch_not_taken_state got=%b exp=00", state); end
    $display("test_branch done");
  endtask

  task automatic test_mem_wait();
    int stalls = 0;
    next_cycle();
    ex_mem_memreq = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (ctl === CTL_MEMW) stalls++;
      total++; if (state !== ((i == 0) ? 2'b00 : 2'b01)) begin bad++; $display("FAIL memwait_state[%0d] got=%b", i, state); end
      next_cycle();
    end
    total++; if (stalls !== 3) begin bad++; $display("FAIL memwait_stalls got=%0d exp=3", stalls); end
    dmem_ready = 1'b1; #1;
    total++; if (ctl !== CTL_DEF) begin bad++; $display("FAIL memwait_release got=%b exp=%b", ctl, CTL_DEF); end
    next_cycle(); set_idle(); #1;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL memwait_back_run got=%b exp=00", state); end
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL memwait_no_err got=%b exp=0", mem_err); end
    $display("test_mem_wait done");
  endtask

  task automatic test_timeout();
    next_cycle();
    ex_mem_memreq = 1'b1; dmem_ready = 1'b0;
    // RUN stall, then MEM_WAIT with counts 1..3 stalling; count 4 times out.
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (ctl !== CTL_MEMW) begin bad++; $display("FAIL timeout_stall[%0d] got=%b exp=%b", i, ctl, CTL_MEMW); end
      next_cycle();
    end
    #1;
    total++; if (ctl !== CTL_DEF) begin bad++; $display("FAIL timeout_release got=%b exp=%b", ctl, CTL_DEF); end
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL timeout_err_early got=%b exp=0", mem_err); end
    next_cycle(); #1;
    total++; if (mem_err !== 1'b1) begin bad++; $display("FAIL timeout_err_set got=%b exp=1", mem_err); end
    total++; if (state !== 2'b00) begin bad++; $display("FAIL timeout_run got=%b exp=00", state); end
    next_cycle(); #1;
    total++; if (state !== 2'b01) begin bad++; $display("FAIL timeout_rewait got=%b exp=01", state); end
    total++; if (mem_err !== 1'b1) begin bad++; $display("FAIL timeout_err_sticky got=%b exp=1", mem_err); end
    rst_n = 1'b0; #1;
    total++; if (state !== 2'b00 || mem_err !== 1'b0) begin bad++; $display("FAIL timeout_mid_reset got=%b/%b exp=00/0", state, mem_err); end
    next_cycle(); set_idle(); rst_n = 1'b1; #1;
    total++; if (ctl !== CTL_DEF) begin bad++; $display("FAIL timeout_post_reset got=%b exp=%b", ctl, CTL_DEF); end
    $display("test_timeout done");
  endtask

  task automatic test_back_to_back();
    next_cycle();
    ex_mem_branch = 1'b1; ex_mem_zero = 1'b1;
    next_cycle();
    ex_mem_branch = 1'b0; ex_mem_zero = 1'b0; ex_mem_memreq = 1'b1; dmem_ready = 1'b0; #1;
    total++; if (ctl !== CTL_MEMW) begin bad++; $display("FAIL b2b_flush_memwait got=%b exp=%b", ctl, CTL_MEMW); end
    next_cycle(); dmem_ready = 1'b1; #1;
    total++; if (state !== 2'b01) begin bad++; $display("FAIL b2b_state got=%b exp=01", state); end
    next_cycle(); set_idle();
    id_ex_memread = 1'b1; id_ex_rt = 5'd9; if_id_rs = 5'd2; if_id_rt = 5'd9; #1;
    total++; if (ctl !== CTL_LDUSE) begin bad++; $display("FAIL b2b_lduse_rt got=%b exp=%b", ctl, CTL_LDUSE); end
    next_cycle(); set_idle();
    $display("test_back_to_back done");
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    test_reset();
`ifdef PIPE_CTL_PERF_EN
    stall_base = stall_cycles;
    flush_base = flush_events;
`endif
    test_load_use();
    test_branch();
    test_mem_wait();
`ifdef PIPE_CTL_PERF_EN
    total++; if (stall_cycles - stall_base !== 32'd4) begin bad++; $display("FAIL perf_stalls got=%0d exp=4", stall_cycles - stall_base); end
    total++; if (flush_events - flush_base !== 32'd1) begin bad++; $display("FAIL perf_flushes got=%0d exp=1", flush_events - flush_base); end
`endif
    test_timeout();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_ctl.md
Name: pipe_ctl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the enable/flush controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers.
- Resolves load-use stalls, taken-branch flushes (branch resolved in MEM) and multi-cycle data-memory waits, with a timeout.
- One instance sits beside the datapath; all pipeline registers take their control from it.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles spent in MEM_WAIT before timeout; legal range 1..255.
- REG_W, 5: register-specifier width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_ex_memread  in  1  instruction in EX is a load
- id_ex_rt  in  REG_W  load destination in EX
- if_id_rs  in  REG_W  rs of instruction in ID
- if_id_rt  in  REG_W  rt of instruction in ID
- ex_mem_branch  in  1  branch control bit of instruction in MEM
- ex_mem_zero  in  1  ALU zero flag latched in EX_MEM
- ex_mem_memreq  in  1  instruction in MEM reads or writes data memory
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC load enable
- pc_src  out  1  1 = select branch target (add_result)
- if_id_en, id_ex_en, ex_mem_en  out  1 each  register load enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  register loads all-zero (bubble)
- mem_err  out  1  sticky memory-timeout flag
- state  out  2  current FSM state

Behaviour:
- Outputs are Mealy: combinational from the state register and the current inputs. A flush takes precedence over the enable: the register loads zero whenever its flush is 1.
- While rst_n=0: state=RUN, wait_cnt=0, mem_err=0. All enables, all flushes and pc_src are forced to 0.
- Defaults (no event): all enables 1, all flushes 0, pc_src 0.
- States and their encodings:
  - RUN: 2'b00
  - MEM_WAIT: 2'b01
  - FLUSH: 2'b10
- RUN evaluates three events. When several are active, the highest priority wins (1 highest):
  1. Branch taken (ex_mem_branch & ex_mem_zero):
     - pc_src=1, pc_en=1.
     - if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
     - Next state FLUSH.
  2. Memory wait (ex_mem_memreq & ~dmem_ready):
     - pc_en=0 and all three register enables 0.
     - mem_wb_flush=1.
     - Next state MEM_WAIT, wait_cnt<=1.
  3. Load-use hazard: id_ex_memread & id_ex_rt!=0 & (id_ex_rt==if_id_rs | id_ex_rt==if_id_rt).
     - pc_en=0, if_id_en=0, id_ex_flush=1.
     - Stay in RUN. The bubble clears the hazard on the next cycle, so the stall is exactly one cycle.
  - A memory access with dmem_ready=1 already in RUN completes with zero extra cycles.
- FLUSH (one cycle):
  - Load-use and branch detection are masked, because the registers hold bubbles.
  - Default outputs apply, except that a memory wait is still honoured (as in RUN).
  - Next state RUN, or MEM_WAIT if a memory wait occurs.
- MEM_WAIT:
  - Branch and load-use inputs are ignored.
  - While dmem_ready=0: stall outputs as in RUN case 2, and wait_cnt increments.
  - When dmem_ready=1: default outputs (the pipeline advances this cycle); next state RUN, wait_cnt<=0.
  - Timeout: if dmem_ready=0 while wait_cnt==MEM_WAIT_MAX, set mem_err<=1, drive default outputs (the access is abandoned and the pipeline released), go to RUN and clear wait_cnt.
  - mem_err is cleared only by reset.
- wait_cnt is 8 bits and never wraps: it saturates at MEM_WAIT_MAX through the timeout exit.
- Reset asserted mid-MEM_WAIT or mid-FLUSH returns immediately to RUN with the counter cleared.

Optional Feature:
- PIPE_CTL_PERF_EN defined:
  - Adds output ports stall_cycles[31:0] and flush_events[31:0], both reset to 0.
  - stall_cycles increments on every cycle with pc_en=0 while rst_n=1.
  - flush_events increments on each taken branch.
  - Both counters wrap modulo 2^32.
- PIPE_CTL_PERF_EN undefined: neither the ports nor the logic exist.

Decomposition:
- Package pipe_pkg holds:
  - state encodings ST_RUN, ST_MEM_WAIT, ST_FLUSH;
  - REG_ZERO=5'd0;
  - the default for the wait-counter width.
- One sub-module, load_use_detect: combinational comparator producing the hazard bit from id_ex_memread, id_ex_rt, if_id_rs and if_id_rt.

Test Plan:
1. Reset: hold rst_n=0 with dmem_ready=0 and ex_mem_memreq=1 -> all enables 0, state=00. Release rst_n -> next cycle state=01 (MEM_WAIT entered).
2. Load-use: id_ex_memread=1, id_ex_rt=5'd8, if_id_rs=5'd8 -> pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle. Repeat with id_ex_rt=0 -> no stall.
3. Branch: ex_mem_branch=1 with ex_mem_zero=1, plus a concurrent load-use -> pc_src=1 and three flushes. Next cycle state=10 with the hazard masked. With ex_mem_zero=0 -> no flush.
4. Memory wait: ex_mem_memreq=1, dmem_ready low for 3 cycles then high -> exactly 3 stall cycles with mem_wb_flush=1, then release and state=00.
5. Timeout: MEM_WAIT_MAX=4, dmem_ready held 0 -> mem_err=1 on the cycle after timeout and stays 1. A mid-wait reset clears it.
6. PIPE_CTL_PERF_EN: run scenarios 2-4 -> stall_cycles=4, flush_events=1.
